// File: rtl/traffic_phase_controller.sv
// Demand-responsive multi-approach traffic phase sequencer: GREEN -> YELLOW -> ALLRED (-> WALK when PED_EN is defined).
// All timing is counted in tick_en pulses; every output is registered and updates on the same edge as the phase change.
module traffic_phase_controller #(
  parameter int NUM_DIRS     = 2,
  parameter int DIR_W        = 3,
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 4,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int PED_TICKS    = 3
) (
`ifdef PED_EN
  input  logic                  ped_req,
  output logic                  walk,
`endif
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  tick_en,
  input  logic [NUM_DIRS-1:0]   sensor,
  output logic [3*NUM_DIRS-1:0] lights,
  output logic [1:0]            phase,
  output logic [DIR_W-1:0]      active_dir
);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_WALK   = 2'd3
  } state_t;

  localparam int NPAD = 1 << DIR_W;
  localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIRS - 1);

  state_t            state;
  logic [CNT_W-1:0]  timer;
  logic [NPAD-1:0]   sens_pad;
  logic [NPAD-1:0]   other_req;
  logic              demand;
  logic [DIR_W-1:0]  next_dir;
  logic              ped_pending;

  function automatic logic [3*NUM_DIRS-1:0] encode(input state_t ph, input logic [DIR_W-1:0] dir);
    logic [3*NUM_DIRS-1:0] v;
    v = '0;
    for (int d = 0; d < NUM_DIRS; d++) begin
      if (dir == DIR_W'(d) && ph == PH_GREEN)       v[3*d]   = 1'b1;
      else if (dir == DIR_W'(d) && ph == PH_YELLOW) v[3*d+1] = 1'b1;
      else                                          v[3*d+2] = 1'b1;
    end
    return v;
  endfunction

  // Wrap is an explicit compare so non-power-of-two NUM_DIRS never visits an unused index.
  function automatic logic [DIR_W-1:0] wrap_inc(input logic [DIR_W-1:0] d);
    return (d == LAST_DIR) ? '0 : d + 1'b1;
  endfunction

  // Scan cyclically starting after the current direction; the current one is visited last.
  function automatic logic [DIR_W-1:0] pick_next(input logic [DIR_W-1:0] cur, input logic [NPAD-1:0] req);
    logic [DIR_W-1:0] idx;
    logic [DIR_W-1:0] res;
    logic             found;
    idx   = cur;
    res   = wrap_inc(cur);
    found = 1'b0;
    for (int i = 0; i < NUM_DIRS; i++) begin
      idx = wrap_inc(idx);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    sens_pad  = NPAD'(sensor);
    other_req = sens_pad & ~(NPAD'(1) << active_dir);
    next_dir  = pick_next(active_dir, sens_pad);
    demand    = (|other_req) | ped_pending;
  end

  assign phase = state;

`ifndef PED_EN
  assign ped_pending = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= PH_ALLRED;
      active_dir <= LAST_DIR;
      timer      <= '0;
      lights     <= encode(PH_ALLRED, LAST_DIR);
`ifdef PED_EN
      walk        <= 1'b0;
      ped_pending <= 1'b0;
`endif
    end else begin
`ifdef PED_EN
      if (ped_req) ped_pending <= 1'b1;
`endif
      if (tick_en) begin
        case (state)
          PH_GREEN: begin
            // Timer saturates at the minimum green; expiry is re-evaluated on every tick until demand shows up.
            if (timer == CNT_W'(GREEN_TICKS - 1)) begin
              if (demand) begin
                state  <= PH_YELLOW;
                timer  <= '0;
                lights <= encode(PH_YELLOW, active_dir);
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          PH_YELLOW: begin
            if (timer == CNT_W'(YELLOW_TICKS - 1)) begin
              timer  <= '0;
              lights <= encode(PH_ALLRED, active_dir);
`ifdef PED_EN
              if (ped_pending) begin
                state       <= PH_WALK;
                walk        <= 1'b1;
                ped_pending <= ped_req;
              end else begin
                state <= PH_ALLRED;
              end
`else
              state <= PH_ALLRED;
`endif
            end else begin
              timer <= timer + 1'b1;
            end
          end
          PH_ALLRED: begin
            if (timer == CNT_W'(ALLRED_TICKS - 1)) begin
              state      <= PH_GREEN;
              timer      <= '0;
              active_dir <= next_dir;
              lights     <= encode(PH_GREEN, next_dir);
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            if (timer == CNT_W'(PED_TICKS - 1)) begin
              state  <= PH_ALLRED;
              timer  <= '0;
              lights <= encode(PH_ALLRED, active_dir);
`ifdef PED_EN
              walk <= 1'b0;
`endif
            end else begin
              timer <= timer + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: 2-approach and 4-approach instances with hand-computed light patterns.
module tb_traffic_phase_controller;

  logic        clk = 1'b0;
  logic        clr, tick_en;
  logic [1:0]  sensor;
  logic [5:0]  lights;
  logic [1:0]  phase;
  logic [2:0]  active_dir;

  logic        clr4, tick4;
  logic [3:0]  sensor4;
  logic [11:0] lights4;
  logic [1:0]  phase4;
  logic [2:0]  dir4;

`ifdef PED_EN
  logic ped_req, walk, ped_req4, walk4;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_phase_controller #(.NUM_DIRS(2)) u_dut (
`ifdef PED_EN
    .ped_req(ped_req), .walk(walk),
`endif
    .clk(clk), .clr(clr), .tick_en(tick_en), .sensor(sensor),
    .lights(lights), .phase(phase), .active_dir(active_dir)
  );

  traffic_phase_controller #(.NUM_DIRS(4)) u_dut4 (
`ifdef PED_EN
    .ped_req(ped_req4), .walk(walk4),
`endif
    .clk(clk), .clr(clr4), .tick_en(tick4), .sensor(sensor4),
    .lights(lights4), .phase(phase4), .active_dir(dir4)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Three idle clocks followed by one tick clock.
  task automatic tick_group();
    tick_en = 1'b0;
    step(3);
    tick_en = 1'b1;
    step(1);
    tick_en = 1'b0;
  endtask

  initial begin
    clr = 1'b1; tick_en = 1'b1; sensor = 2'b00;
    clr4 = 1'b1; tick4 = 1'b1; sensor4 = 4'b0000;
`ifdef PED_EN
    ped_req = 1'b0; ped_req4 = 1'b0;
`endif
    step(2);
    chk("rst_lights", 32'(lights), 32'h24);
    chk("rst_phase", 32'(phase), 32'd2);
    chk("rst_dir", 32'(active_dir), 32'd1);

    clr = 1'b0;
    step(1);
    chk("rel_phase", 32'(phase), 32'd0);
    chk("rel_dir", 32'(active_dir), 32'd0);
    chk("rel_lights", 32'(lights), 32'h21);

    // Full demand: 4 green, 2 yellow, 1 all-red per approach.
    sensor = 2'b11;
    step(3);
    chk("fd_green_hold", 32'(lights), 32'h21);
    step(1);
    chk("fd_yellow", 32'(lights), 32'h22);
    chk("fd_yellow_ph", 32'(phase), 32'd1);
    step(1);
    chk("fd_yellow2", 32'(lights), 32'h22);
    step(1);
    chk("fd_allred", 32'(lights), 32'h24);
    chk("fd_allred_ph", 32'(phase), 32'd2);
    step(1);
    chk("fd_dir1_green", 32'(lights), 32'h0c);
    chk("fd_dir1", 32'(active_dir), 32'd1);
    step(4);
    chk("fd_dir1_yellow", 32'(lights), 32'h14);
    step(3);
    chk("fd_period_dir0", 32'(lights), 32'h21);
    step(7);
    chk("fd_period_dir1", 32'(lights), 32'h0c);
    step(7);
    chk("fd_back_dir0", 32'(active_dir), 32'd0);

    // Green extension: only the served approach requests.
    sensor = 2'b01;
    step(10);
    chk("ext_hold", 32'(lights), 32'h21);
    chk("ext_hold_ph", 32'(phase), 32'd0);
    sensor = 2'b11;
    step(1);
    chk("ext_yellow", 32'(phase), 32'd1);
    step(3);
    chk("ext_dir1", 32'(lights), 32'h0c);

    // Prescaled timebase: one tick every 4 clocks.
    tick_group(); tick_group(); tick_group();
    tick_en = 1'b0;
    step(3);
    chk("pre_green_16", 32'(lights), 32'h0c);
    tick_en = 1'b1;
    step(1);
    chk("pre_yellow", 32'(lights), 32'h14);
    tick_group();
    step(1);
    chk("pre_yellow_hold", 32'(phase), 32'd1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("mid_rst_lights", 32'(lights), 32'h24);
    chk("mid_rst_phase", 32'(phase), 32'd2);
    chk("mid_rst_dir", 32'(active_dir), 32'd1);
    step(2);
    chk("notick_hold", 32'(phase), 32'd2);
    tick_en = 1'b1;
    step(1);
    chk("post_rst_green", 32'(lights), 32'h21);

`ifdef PED_EN
    // Pedestrian request with no vehicle demand.
    sensor = 2'b00;
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    step(3);
    chk("ped_yellow", 32'(phase), 32'd1);
    step(2);
    chk("ped_walk_ph", 32'(phase), 32'd3);
    chk("ped_walk", 32'(walk), 32'd1);
    chk("ped_walk_lights", 32'(lights), 32'h24);
    step(2);
    chk("ped_walk_hold", 32'(phase), 32'd3);
    step(1);
    chk("ped_allred", 32'(phase), 32'd2);
    chk("ped_walk_off", 32'(walk), 32'd0);
    step(1);
    chk("ped_rr_dir", 32'(active_dir), 32'd1);
`endif

    // Four approaches: skip idle approaches 1 and 2.
    chk("d4_rst_dir", 32'(dir4), 32'd3);
    chk("d4_rst_lights", 32'(lights4), 32'h924);
    clr4 = 1'b0; sensor4 = 4'b1001;
    step(1);
    chk("d4_dir0", 32'(dir4), 32'd0);
    chk("d4_dir0_lights", 32'(lights4), 32'h921);
    step(4);
    chk("d4_yellow", 32'(lights4), 32'h922);
    step(3);
    chk("d4_skip_dir3", 32'(dir4), 32'd3);
    chk("d4_dir3_lights", 32'(lights4), 32'h324);
    step(7);
    chk("d4_wrap_dir0", 32'(dir4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Parametrised successor to the two-way traffic light controller.
- Sequences NUM_DIRS approaches through GREEN -> YELLOW -> ALL-RED with per-phase durations counted in tick_en pulses.
- Adds demand-responsive behaviour: extends green while no other approach requests, and skips approaches with no vehicle sensor demand.
- Sits between the board prescaler (tick_en) and the light-driver pins.

Parameters:
NUM_DIRS, 2, number of approaches (2..8)
DIR_W, 3, width of active_dir index (must satisfy 2**DIR_W >= NUM_DIRS)
CNT_W, 8, phase timer width
GREEN_TICKS, 4, minimum green duration in ticks (1..2**CNT_W-1)
YELLOW_TICKS, 2, yellow duration in ticks (>=1)
ALLRED_TICKS, 1, all-red clearance in ticks (>=1)
PED_TICKS, 3, walk duration in ticks (PED_EN only)

Ports:
clk  in  1  system clock; all state updates on rising edge
clr  in  1  synchronous active-high reset
tick_en  in  1  one-cycle timebase enable; timers advance only when high
sensor  in  NUM_DIRS  vehicle demand per approach, level, sampled each clk
lights  out  3*NUM_DIRS  per approach d: bit 3d+2=RED, 3d+1=YELLOW, 3d=GREEN; registered
phase  out  2  0=GREEN, 1=YELLOW, 2=ALLRED, 3=WALK; registered
active_dir  out  DIR_W  approach currently or last served; registered
ped_req  in  1  pedestrian button pulse (PED_EN only)
walk  out  1  walk lamp (PED_EN only)

Behaviour:
- Reset (clr=1 at an edge, dominates all inputs): phase=ALLRED, active_dir=NUM_DIRS-1, timer=0, lights all RED (only bits 3d+2 set), walk=0, ped_pending=0. Reset mid-phase takes effect on the next edge.
- Light encoding: exactly one of R/Y/G set per approach at all times. Only active_dir shows GREEN or YELLOW; all others are RED. ALLRED and WALK show all RED.
- Timer: resets to 0 on every phase change. Increments on an edge with tick_en=1. A phase of duration D ends on the edge where tick_en=1 and timer==D-1. lights, phase and active_dir update on that same edge, with zero added latency.
- GREEN: at expiry, if any sensor[k] (k!=active_dir) or ped_pending is set, go to YELLOW. Otherwise hold GREEN with the timer saturated at GREEN_TICKS-1, and re-evaluate on every tick_en until demand appears.
- YELLOW: at expiry, go to WALK if ped_pending (PED_EN), else ALLRED.
- ALLRED: at expiry, go to GREEN. The new active_dir is the first index after active_dir, cyclically (wrap NUM_DIRS-1 -> 0), with sensor set at that edge. If no sensor is set, active_dir+1 mod NUM_DIRS (plain round-robin). The current direction is considered last.
- tick_en=0: no timer advance and no transitions. sensor changes are still observed at the next tick.
- NUM_DIRS is not a power of two: the index wrap uses an explicit compare, not modulo-by-overflow.

Optional Feature:
PED_EN
- Defined:
  - ped_req and walk ports exist.
  - ped_req=1 on any edge sets ped_pending; ped_pending is cleared on entry to WALK.
  - ped_pending counts as demand for GREEN termination.
  - YELLOW -> WALK (phase=3, walk=1, all RED) for PED_TICKS, then ALLRED. active_dir is unchanged through WALK.
  - ped_req during WALK re-latches and is served at the next cycle.
- Undefined: no ped_req/walk ports, phase never 3, YELLOW always -> ALLRED.

Test Plan:
- Reset: NUM_DIRS=2, tick_en=1, sensor=00. clr=1 for 2 cycles -> lights=6'b100100, phase=2, active_dir=1. 1 edge after release -> phase=0, active_dir=0, lights=6'b100001.
- Full demand: sensor=11, tick_en=1 -> dir0 green 4 cycles, yellow (6'b100010) 2, allred 1, then dir1 green (6'b001100). Period 14 clk, repeating.
- Green extension: sensor=01 -> dir0 stays 6'b100001 beyond 4 cycles. Raise sensor[1] at cycle 20 -> YELLOW on the next edge, dir1 green 3 edges later.
- Skip: NUM_DIRS=4, sensor=4'b1001, active_dir=0 green -> after yellow/allred active_dir=3 (dirs 1,2 skipped). Next served is 0 (wrap).
- Prescale and reset: tick_en every 4th clk, sensor=11 -> green 16, yellow 8, allred 4 clk. clr asserted during YELLOW -> next edge all RED, phase=2, active_dir=NUM_DIRS-1.
- PED_EN: ped_req 1-cycle pulse during dir0 green with sensor=00 -> yellow at green expiry, then phase=3, walk=1 for 3 ticks, allred, then green per round-robin.
